// File: rtl/rv32_prog_loader.sv
// rv32_prog_loader: streams host words into the imem/dmem write ports of selected harts, holding them in program mode
//   cmd_*        load command (target, hart mask, base word address, length); cmd_ready high in IDLE
//   abort        cancels a load in progress; ignored in IDLE
//   s_*          word stream; s_ready high while words are still owed in WRITE
//   imem_w_en / dmem_w_en / mem_addr / mem_data   registered broadcast write port
//   program_o    per-hart hold (core rv32_io_program); named with a suffix because "program" is reserved
//   busy, done, err, checksum   status; checksum sums the words written by the current or last load
module rv32_prog_loader #(
   parameter int NUM_HARTS   = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_WORDS   = 4096,
   parameter int HOLD_CYCLES = 4,
   localparam int LEN_W      = $clog2(MAX_WORDS) + 1
) (
   input  logic                 rv32_io_clk,
   input  logic                 rv32_io_rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_target,
   input  logic [NUM_HARTS-1:0] cmd_hart_mask,
   input  logic [ADDR_W-1:0]    cmd_base,
   input  logic [LEN_W-1:0]     cmd_len,
   input  logic                 abort,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATA_W-1:0]    s_data,
   output logic [NUM_HARTS-1:0] imem_w_en,
   output logic [NUM_HARTS-1:0] dmem_w_en,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_data,
   output logic [NUM_HARTS-1:0] program_o,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [DATA_W-1:0]    checksum
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;
   localparam int HC_W = $clog2(HOLD_CYCLES + 1);

   logic [1:0]           state_q, state_d;
   logic [HC_W-1:0]      hold_q, hold_d;
   logic [LEN_W-1:0]     idx_q, idx_d, len_q, len_d;
   logic                 tgt_q, tgt_d;
   logic [NUM_HARTS-1:0] mask_q, mask_d;
   logic [ADDR_W-1:0]    nxt_q, nxt_d;
   logic [NUM_HARTS-1:0] imem_q, imem_d, dmem_q, dmem_d, prog_q, prog_d;
   logic [ADDR_W-1:0]    wa_q, wa_d;
   logic [DATA_W-1:0]    wd_q, wd_d, csum_q, csum_d;
   logic                 done_q, done_d, err_q, err_d;
   logic [LEN_W-1:0]     idx_inc;

   assign idx_inc = idx_q + LEN_W'(1);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      mask_d  = mask_q;
      nxt_d   = nxt_q;
      imem_d  = '0;
      dmem_d  = '0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      prog_d  = prog_q;
      csum_d  = csum_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == S_IDLE) begin
         if (cmd_valid) begin
            if (cmd_len == '0 || cmd_len > LEN_W'(MAX_WORDS) || cmd_hart_mask == '0) begin
               err_d = 1'b1;
            end else begin
               state_d = S_HOLD;
               hold_d  = '0;
               idx_d   = '0;
               len_d   = cmd_len;
               tgt_d   = cmd_target;
               mask_d  = cmd_hart_mask;
               nxt_d   = cmd_base;
               prog_d  = cmd_hart_mask;
               csum_d  = '0;
            end
         end
      end else if (abort) begin
         // abort outranks a same-cycle handshake, so that word is neither written nor summed
         state_d = S_IDLE;
         prog_d  = '0;
         err_d   = 1'b1;
      end else if (state_q == S_HOLD) begin
         state_d = hold_q == HC_W'(HOLD_CYCLES - 1) ? S_WRITE : S_HOLD;
         hold_d  = hold_q + HC_W'(1);
      end else if (state_q == S_WRITE) begin
         if (s_valid) begin
            imem_d  = tgt_q ? '0 : mask_q;
            dmem_d  = tgt_q ? mask_q : '0;
            wa_d    = nxt_q;
            wd_d    = s_data;
            csum_d  = csum_q + s_data;
            nxt_d   = nxt_q + ADDR_W'(1);
            idx_d   = idx_inc;
            state_d = idx_inc == len_q ? S_RELEASE : S_WRITE;
         end
      end else begin
         // RELEASE: the last write is on the port now, so program can drop on the next edge
         state_d = S_IDLE;
         prog_d  = '0;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge rv32_io_clk or posedge rv32_io_rst) begin
      if (rv32_io_rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         tgt_q   <= 1'b0;
         mask_q  <= '0;
         nxt_q   <= '0;
         imem_q  <= '0;
         dmem_q  <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         prog_q  <= '0;
         csum_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         mask_q  <= mask_d;
         nxt_q   <= nxt_d;
         imem_q  <= imem_d;
         dmem_q  <= dmem_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         prog_q  <= prog_d;
         csum_q  <= csum_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // handshake flags decode the state register only, so no input reaches an output combinationally
   assign cmd_ready = state_q == S_IDLE;
   assign busy      = state_q != S_IDLE;
   assign s_ready   = state_q == S_WRITE;
   assign imem_w_en = imem_q;
   assign dmem_w_en = dmem_q;
   assign mem_addr  = wa_q;
   assign mem_data  = wd_q;
   assign program_o = prog_q;
   assign done      = done_q;
   assign err       = err_q;
   assign checksum  = csum_q;
endmodule

// File: tb/tb_rv32_prog_loader.sv
// tb_rv32_prog_loader: directed loads checked every cycle against a transaction-level model plus literal expectations
module tb_rv32_prog_loader;
   localparam int NH = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4096;
   localparam int H  = 4;
   localparam int LW = 13;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_target = 1'b0;
   logic [NH-1:0] cmd_hart_mask = '0;
   logic [AW-1:0] cmd_base = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          abort = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          cmd_ready, s_ready, busy, done, err;
   logic [NH-1:0] imem_w_en, dmem_w_en, program_o;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data, checksum;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rv32_prog_loader #(.NUM_HARTS(NH), .ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MW), .HOLD_CYCLES(H)) dut (
      .rv32_io_clk(clk), .rv32_io_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_hart_mask(cmd_hart_mask), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .imem_w_en(imem_w_en), .dmem_w_en(dmem_w_en), .mem_addr(mem_addr), .mem_data(mem_data),
      .program_o(program_o), .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   // Model: tracks the load as "accepted at edge m_acc, m_cnt of m_len words taken"; stream may flow
   // once HOLD edges have passed, a word taken on edge k is the write shown after edge k, and the edge
   // after the last word is taken ends the load.
   int            cyc = 0;
   bit            m_act = 1'b0;
   int            m_acc = 0, m_len = 0, m_cnt = 0;
   bit            m_tgt = 1'b0;
   logic [NH-1:0] m_mask = '0;
   logic [AW-1:0] m_base = '0;
   logic          e_sready = 1'b0, e_done = 1'b0, e_err = 1'b0;
   logic [NH-1:0] e_imem = '0, e_dmem = '0, e_prog = '0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_data = '0, e_sum = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_act = 1'b0; e_sready = 1'b0; e_done = 1'b0; e_err = 1'b0;
         e_imem = '0; e_dmem = '0; e_prog = '0; e_addr = '0; e_data = '0; e_sum = '0;
      end else begin
         bit took;
         took = m_act && e_sready && s_valid;
         cyc++;
         e_imem = '0; e_dmem = '0; e_done = 1'b0; e_err = 1'b0;
         if (!m_act) begin
            if (cmd_valid) begin
               if (int'(cmd_len) == 0 || int'(cmd_len) > MW || cmd_hart_mask == '0) e_err = 1'b1;
               else begin
                  m_act = 1'b1; m_acc = cyc; m_len = int'(cmd_len); m_cnt = 0; m_tgt = cmd_target;
                  m_mask = cmd_hart_mask; m_base = cmd_base; e_sum = '0; e_prog = cmd_hart_mask;
               end
            end
         end else if (abort) begin
            m_act = 1'b0; e_prog = '0; e_err = 1'b1;
         end else if (m_cnt == m_len) begin
            m_act = 1'b0; e_prog = '0; e_done = 1'b1;
         end else if (took) begin
            if (m_tgt) e_dmem = m_mask; else e_imem = m_mask;
            e_addr = m_base + AW'(m_cnt);
            e_data = s_data;
            e_sum  = e_sum + s_data;
            m_cnt++;
         end
         e_sready = m_act && cyc >= m_acc + H && m_cnt < m_len;
      end
   end

   logic [AW-1:0] q_addr[$];
   logic [NH-1:0] q_im[$], q_dm[$];
   int            q_done[$];

   initial forever begin
      @(negedge clk);
      chk("cmd_ready", 64'(cmd_ready), 64'(!m_act));
      chk("busy", 64'(busy), 64'(m_act));
      chk("s_ready", 64'(s_ready), 64'(e_sready));
      chk("imem_w_en", 64'(imem_w_en), 64'(e_imem));
      chk("dmem_w_en", 64'(dmem_w_en), 64'(e_dmem));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_data", 64'(mem_data), 64'(e_data));
      chk("program", 64'(program_o), 64'(e_prog));
      chk("done", 64'(done), 64'(e_done));
      chk("err", 64'(err), 64'(e_err));
      chk("checksum", 64'(checksum), 64'(e_sum));
      if (imem_w_en != '0 || dmem_w_en != '0) begin
         q_addr.push_back(mem_addr);
         q_im.push_back(imem_w_en);
         q_dm.push_back(dmem_w_en);
      end
      if (done) q_done.push_back(cyc);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      q_addr.delete(); q_im.delete(); q_dm.delete(); q_done.delete();
   endtask

   task automatic send_cmd(input bit t, input logic [NH-1:0] m, input logic [AW-1:0] b, input int n);
      cmd_target = t; cmd_hart_mask = m; cmd_base = b; cmd_len = LW'(n); cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic stream(input logic [DW-1:0] w[$], input bit gap);
      foreach (w[i]) begin
         bit hs;
         int tmo;
         s_valid = 1'b1; s_data = w[i]; tmo = 0;
         do begin
            hs = s_ready;
            step();
            tmo++;
         end while (!hs && tmo < 40);
         if (!hs) chk("stream_timeout", 64'(0), 64'(1));
         s_valid = 1'b0;
         if (gap) step();
      end
   endtask

   task automatic wait_done();
      int tmo;
      tmo = 0;
      while (!done && tmo < 60) begin
         step();
         tmo++;
      end
      chk("done_seen", 64'(done), 64'(1));
      step();
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      chk({nm, "_s_ready"}, 64'(s_ready), 64'(0));
      chk({nm, "_en"}, 64'({imem_w_en, dmem_w_en}), 64'(0));
      chk({nm, "_program"}, 64'(program_o), 64'(0));
      chk({nm, "_flags"}, 64'({busy, done, err}), 64'(0));
      chk({nm, "_addr_data"}, {mem_addr, mem_data}, 64'(0));
      chk({nm, "_checksum"}, 64'(checksum), 64'(0));
   endtask

   initial begin
      logic [DW-1:0] w[$];
      int acc;
      #1 rst = 1'b1;
      #2 check_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      step();

      // basic imem load, continuous stream
      clear_logs();
      send_cmd(1'b0, 4'b0001, 32'h0, 4);
      acc = m_acc;
      chk("t1_program_on_accept", 64'(program_o), 64'(4'b0001));
      w = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
      stream(w, 1'b0);
      wait_done();
      chk("t1_writes", 64'(q_addr.size()), 64'(4));
      foreach (q_addr[i]) begin
         chk("t1_addr", 64'(q_addr[i]), 64'(i));
         chk("t1_imem_en", 64'(q_im[i]), 64'(4'b0001));
         chk("t1_dmem_en", 64'(q_dm[i]), 64'(0));
      end
      chk("t1_checksum", 64'(checksum), 64'(32'h0060834C));
      // accept cycle + 4 hold + 4 words + release + done cycle = 11 cycles: done shows 9 edges after the accept edge
      chk("t1_done_latency", 64'(q_done.size() > 0 ? q_done[0] - acc : -1), 64'(9));

      // broadcast dmem load with a bubble between words
      clear_logs();
      send_cmd(1'b1, 4'b1010, 32'h100, 3);
      w = '{32'hA, 32'hB, 32'hC};
      stream(w, 1'b1);
      wait_done();
      chk("t2_writes", 64'(q_addr.size()), 64'(3));
      foreach (q_addr[i]) begin
         chk("t2_addr", 64'(q_addr[i]), 64'(32'h100 + i));
         chk("t2_dmem_en", 64'(q_dm[i]), 64'(4'b1010));
         chk("t2_imem_en", 64'(q_im[i]), 64'(0));
      end
      chk("t2_checksum", 64'(checksum), 64'(32'h21));

      // address wrap
      clear_logs();
      send_cmd(1'b0, 4'b0100, 32'hFFFFFFFE, 4);
      w = '{32'h1, 32'h2, 32'h3, 32'h4};
      stream(w, 1'b0);
      wait_done();
      chk("t3_writes", 64'(q_addr.size()), 64'(4));
      if (q_addr.size() == 4) begin
         chk("t3_addr0", 64'(q_addr[0]), 64'(32'hFFFFFFFE));
         chk("t3_addr1", 64'(q_addr[1]), 64'(32'hFFFFFFFF));
         chk("t3_addr2", 64'(q_addr[2]), 64'(32'h0));
         chk("t3_addr3", 64'(q_addr[3]), 64'(32'h1));
      end
      chk("t3_checksum", 64'(checksum), 64'(32'hA));

      // rejected commands: zero length, too long, empty mask
      send_cmd(1'b0, 4'b0001, 32'h0, 0);
      chk("rej_len0", 64'({err, busy, program_o}), 64'({1'b1, 1'b0, 4'b0000}));
      send_cmd(1'b0, 4'b0001, 32'h0, MW + 1);
      chk("rej_long", 64'({err, busy, program_o}), 64'({1'b1, 1'b0, 4'b0000}));
      send_cmd(1'b1, 4'b0000, 32'h0, 4);
      chk("rej_mask0", 64'({err, busy, program_o}), 64'({1'b1, 1'b0, 4'b0000}));
      step();
      chk("rej_err_one_cycle", 64'(err), 64'(0));

      // abort after the 2nd write, together with a 3rd handshake
      clear_logs();
      send_cmd(1'b0, 4'b0001, 32'h40, 8);
      w = '{32'h11111111, 32'h22222222};
      stream(w, 1'b0);
      s_valid = 1'b1; s_data = 32'h44444444; abort = 1'b1;
      step();
      abort = 1'b0; s_valid = 1'b0;
      chk("ab_program", 64'(program_o), 64'(0));
      chk("ab_err", 64'(err), 64'(1));
      chk("ab_no_en", 64'({imem_w_en, dmem_w_en}), 64'(0));
      chk("ab_checksum", 64'(checksum), 64'(32'h33333333));
      step(); step();
      chk("ab_writes", 64'(q_addr.size()), 64'(2));
      send_cmd(1'b1, 4'b1111, 32'h300, 2);
      chk("ab_new_accept", 64'(busy), 64'(1));
      w = '{32'h5, 32'h6};
      stream(w, 1'b0);
      wait_done();
      chk("ab_new_checksum", 64'(checksum), 64'(32'hB));

      // asynchronous reset in the middle of WRITE
      clear_logs();
      send_cmd(1'b1, 4'b0100, 32'h20, 8);
      w = '{32'h7, 32'h8, 32'h9};
      stream(w, 1'b0);
      s_valid = 1'b1; s_data = 32'hA;
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_mid");
      @(posedge clk); @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0;
      step();
      clear_logs();
      send_cmd(1'b0, 4'b0010, 32'h80, 1);
      w = '{32'hDEADBEEF};
      stream(w, 1'b0);
      wait_done();
      chk("rst_after_writes", 64'(q_addr.size()), 64'(1));
      if (q_addr.size() == 1) chk("rst_after_addr", 64'(q_addr[0]), 64'(32'h80));
      chk("rst_after_checksum", 64'(checksum), 64'(32'hDEADBEEF));

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
